// File: rtl/rtc_bcd_counter.sv
// Time-of-day counter in packed BCD (hh:mm:ss) driven by a single clock and an
// internal second prescaler, with checked time/alarm loads and a 12h display view.
module rtc_bcd_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int PRE_W    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       load,
    input  logic [7:0] load_hour,
    input  logic [7:0] load_minute,
    input  logic [7:0] load_second,
    input  logic       alarm_set,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_minute,
    input  logic       alarm_en,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       pm,
    output logic       s_bit,
    output logic       m_bit,
    output logic       h_bit,
    output logic       alarm,
    output logic       load_err
);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [7:0]       alarmHour_q, alarmHour_d, alarmMin_q, alarmMin_d;
    logic             sBit_q, sBit_d, mBit_q, mBit_d, hBit_q, hBit_d;
    logic             alarm_q, alarm_d, loadErr_q, loadErr_d;

    logic             tick, loadOk, alarmOk, secWrap, minWrap, dayWrap, alarmMatch;
    logic [7:0]       secInc, minInc, hourInc;
    logic [4:0]       hourBin, hour12Bin;
    logic [7:0]       hour12Bcd;

    function automatic logic bcdOk(input logic [7:0] v, input logic [7:0] maxV);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= maxV);
    endfunction

    // Two-digit BCD counter 00..59; the caller decides whether to wrap past 59.
    function automatic logic [7:0] nextSixty(input logic [7:0] v);
        if (v[3:0] != 4'd9)
            return {v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] == 4'd5)
            return 8'h00;
        else
            return {v[7:4] + 4'd1, 4'd0};
    endfunction

    function automatic logic [7:0] nextHour(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        tick       = run && (pre_q == PRE_W'(TICK_DIV - 1));
        loadOk     = bcdOk(load_hour, 8'h23) && bcdOk(load_minute, 8'h59)
                     && bcdOk(load_second, 8'h59);
        alarmOk    = bcdOk(alarm_hour, 8'h23) && bcdOk(alarm_minute, 8'h59);
        secWrap    = (sec_q == 8'h59);
        minWrap    = (min_q == 8'h59);
        dayWrap    = (hour_q == 8'h23);
        secInc     = nextSixty(sec_q);
        minInc     = secWrap ? nextSixty(min_q) : min_q;
        hourInc    = (secWrap && minWrap) ? nextHour(hour_q) : hour_q;
        alarmMatch = alarm_en && secWrap && (hourInc == alarmHour_q) && (minInc == alarmMin_q);
    end

    // A valid load takes priority over a coincident tick, which is simply discarded.
    always_comb begin
        pre_d       = pre_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        alarmHour_d = alarmHour_q;
        alarmMin_d  = alarmMin_q;
        sBit_d      = 1'b0;
        mBit_d      = 1'b0;
        hBit_d      = 1'b0;
        alarm_d     = 1'b0;
        loadErr_d   = (load && !loadOk) || (alarm_set && !alarmOk);

        if (load && loadOk) begin
            hour_d = load_hour;
            min_d  = load_minute;
            sec_d  = load_second;
            pre_d  = '0;
        end else if (tick) begin
            hour_d  = hourInc;
            min_d   = minInc;
            sec_d   = secInc;
            pre_d   = '0;
            sBit_d  = secWrap;
            mBit_d  = secWrap && minWrap;
            hBit_d  = secWrap && minWrap && dayWrap;
            alarm_d = alarmMatch;
        end else if (run) begin
            pre_d = pre_q + PRE_W'(1);
        end

        if (alarm_set && alarmOk) begin
            alarmHour_d = alarm_hour;
            alarmMin_d  = alarm_minute;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q       <= '0;
            hour_q      <= 8'h00;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            alarmHour_q <= 8'h00;
            alarmMin_q  <= 8'h00;
            sBit_q      <= 1'b0;
            mBit_q      <= 1'b0;
            hBit_q      <= 1'b0;
            alarm_q     <= 1'b0;
            loadErr_q   <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            alarmHour_q <= alarmHour_d;
            alarmMin_q  <= alarmMin_d;
            sBit_q      <= sBit_d;
            mBit_q      <= mBit_d;
            hBit_q      <= hBit_d;
            alarm_q     <= alarm_d;
            loadErr_q   <= loadErr_d;
        end
    end

    // 12h view: 00 and 12 both show as 12, afternoon hours drop by twelve.
    always_comb begin
        hourBin   = 5'(hour_q[7:4]) * 5'd10 + 5'(hour_q[3:0]);
        hour12Bin = hourBin;
        if (hourBin == 5'd0)
            hour12Bin = 5'd12;
        else if (hourBin > 5'd12)
            hour12Bin = hourBin - 5'd12;
        if (hour12Bin >= 5'd10)
            hour12Bcd = {4'd1, 4'(hour12Bin - 5'd10)};
        else
            hour12Bcd = {4'd0, hour12Bin[3:0]};
    end

    assign hour     = mode_12h ? hour12Bcd : hour_q;
    assign minute   = min_q;
    assign second   = sec_q;
    assign pm       = (hour_q >= 8'h12);
    assign s_bit    = sBit_q;
    assign m_bit    = mBit_q;
    assign h_bit    = hBit_q;
    assign alarm    = alarm_q;
    assign load_err = loadErr_q;

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Bench for rtc_bcd_counter: directed scenarios plus random traffic, all checked
// against a seconds-of-day reference model.
module tb_rtc_bcd_counter;

    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       reset, run, mode_12h, load, alarm_set, alarm_en;
    logic [7:0] load_hour, load_minute, load_second, alarm_hour, alarm_minute;
    logic [7:0] hour, minute, second;
    logic       pm, s_bit, m_bit, h_bit, alarm, load_err;

    int checks   = 0;
    int failures = 0;

    int tod, preCnt, alarmMod;
    bit expS, expM, expH, expAl, expErr;

    always #5 clk = ~clk;

    rtc_bcd_counter #(.TICK_DIV(TDIV), .PRE_W(3)) dut (
        .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h),
        .load(load), .load_hour(load_hour), .load_minute(load_minute),
        .load_second(load_second), .alarm_set(alarm_set), .alarm_hour(alarm_hour),
        .alarm_minute(alarm_minute), .alarm_en(alarm_en), .hour(hour),
        .minute(minute), .second(second), .pm(pm), .s_bit(s_bit), .m_bit(m_bit),
        .h_bit(h_bit), .alarm(alarm), .load_err(load_err)
    );

    function automatic bit bcdInRange(logic [7:0] v, int lim);
        return (v[3:0] <= 4'd9) && (int'(v[7:4]) * 10 + int'(v[3:0]) <= lim);
    endfunction

    function automatic int bcdVal(logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] toBcd(int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, expected, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit lOk, aOk;
        int newTod;
        if (reset) begin
            tod = 0; preCnt = 0; alarmMod = 0;
            expS = 0; expM = 0; expH = 0; expAl = 0; expErr = 0;
        end else begin
            lOk = bcdInRange(load_hour, 23) && bcdInRange(load_minute, 59)
                  && bcdInRange(load_second, 59);
            aOk = bcdInRange(alarm_hour, 23) && bcdInRange(alarm_minute, 59);
            expS = 0; expM = 0; expH = 0; expAl = 0;
            expErr = (load && !lOk) || (alarm_set && !aOk);
            if (load && lOk) begin
                tod    = bcdVal(load_hour) * 3600 + bcdVal(load_minute) * 60 + bcdVal(load_second);
                preCnt = 0;
            end else if (run) begin
                if (preCnt == TDIV - 1) begin
                    preCnt = 0;
                    newTod = (tod + 1) % 86400;
                    expS   = (newTod % 60 == 0);
                    expM   = (newTod % 3600 == 0);
                    expH   = (newTod == 0);
                    expAl  = alarm_en && (newTod == alarmMod * 60);
                    tod    = newTod;
                end else begin
                    preCnt++;
                end
            end
            if (alarm_set && aOk)
                alarmMod = bcdVal(alarm_hour) * 60 + bcdVal(alarm_minute);
        end
    endtask

    task automatic compareAll();
        int hh;
        logic [7:0] expHour;
        hh = tod / 3600;
        expHour = mode_12h ? toBcd((hh % 12 == 0) ? 12 : hh % 12) : toBcd(hh);
        checkOutput("hour", hour, expHour);
        checkOutput("minute", minute, toBcd((tod / 60) % 60));
        checkOutput("second", second, toBcd(tod % 60));
        checkOutput("pm", pm, hh >= 12);
        checkOutput("pulses", {s_bit, m_bit, h_bit, alarm, load_err},
                    {expS, expM, expH, expAl, expErr});
    endtask

    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic idle(int n);
        repeat (n) applyStimulus();
    endtask

    task automatic doLoad(logic [7:0] h, logic [7:0] m, logic [7:0] s);
        load = 1'b1; load_hour = h; load_minute = m; load_second = s;
        applyStimulus();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; mode_12h = 1'b0; load = 1'b0; alarm_set = 1'b0;
        alarm_en = 1'b0; load_hour = 8'h00; load_minute = 8'h00; load_second = 8'h00;
        alarm_hour = 8'h00; alarm_minute = 8'h00;

        $display("[TB] reset and frozen prescaler");
        idle(3);
        checkOutput("t1_reset", {hour, minute, second, pm}, 25'h0);
        reset = 1'b0;
        idle(20);
        checkOutput("t1_frozen", {hour, minute, second}, 24'h0);

        $display("[TB] second carry");
        run = 1'b1;
        doLoad(8'h00, 8'h00, 8'h58);
        idle(3);
        applyStimulus();
        checkOutput("t2_s59", second, 8'h59);
        idle(3);
        applyStimulus();
        checkOutput("t2_min", {minute, second, s_bit, m_bit}, {16'h0100, 2'b10});

        $display("[TB] day wrap");
        doLoad(8'h23, 8'h59, 8'h59);
        idle(3);
        applyStimulus();
        checkOutput("t3_wrap", {hour, minute, second, s_bit, m_bit, h_bit}, {24'h0, 3'b111});
        idle(2);

        $display("[TB] rejected loads and load on tick");
        doLoad(8'h24, 8'h00, 8'h00);
        doLoad(8'h12, 8'h60, 8'h00);
        doLoad(8'h1A, 8'h00, 8'h00);
        doLoad(8'h10, 8'h00, 8'h00);
        idle(3);
        doLoad(8'h05, 8'h06, 8'h07);
        checkOutput("t4_tickload", {hour, minute, second}, 24'h050607);
        idle(2);

        $display("[TB] 12h display");
        run = 1'b0; mode_12h = 1'b1;
        doLoad(8'h00, 8'h00, 8'h00);
        checkOutput("t5_h00", {hour, pm}, {8'h12, 1'b0});
        doLoad(8'h12, 8'h00, 8'h00);
        checkOutput("t5_h12", {hour, pm}, {8'h12, 1'b1});
        doLoad(8'h13, 8'h05, 8'h00);
        checkOutput("t5_h13", {hour, pm}, {8'h01, 1'b1});
        doLoad(8'h23, 8'h59, 8'h00);
        checkOutput("t5_h23", {hour, pm}, {8'h11, 1'b1});
        mode_12h = 1'b0;

        $display("[TB] alarm");
        alarm_set = 1'b1; alarm_hour = 8'h07; alarm_minute = 8'h30; alarm_en = 1'b1;
        applyStimulus();
        alarm_set = 1'b0; run = 1'b1;
        doLoad(8'h07, 8'h29, 8'h59);
        idle(3);
        applyStimulus();
        checkOutput("t6_fire", alarm, 1'b1);
        alarm_en = 1'b0;
        doLoad(8'h07, 8'h29, 8'h59);
        idle(3);
        applyStimulus();
        checkOutput("t6_disabled", alarm, 1'b0);
        alarm_en = 1'b1;
        doLoad(8'h07, 8'h30, 8'h00);
        checkOutput("t6_loadquiet", alarm, 1'b0);
        idle(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            int mm;
            reset    = ($urandom_range(0, 199) == 0);
            run      = ($urandom_range(0, 9) != 0);
            mode_12h = $urandom_range(0, 1) != 0;
            alarm_en = ($urandom_range(0, 4) != 0);
            load     = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) begin
                load_hour = 8'($urandom); load_minute = 8'($urandom); load_second = 8'($urandom);
            end else begin
                load_hour   = toBcd($urandom_range(0, 23));
                load_minute = ($urandom_range(0, 1) != 0) ? 8'h59 : toBcd($urandom_range(0, 59));
                load_second = ($urandom_range(0, 1) != 0) ? toBcd($urandom_range(55, 59))
                                                          : toBcd($urandom_range(0, 59));
            end
            alarm_set = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) begin
                alarm_hour = 8'($urandom); alarm_minute = 8'($urandom);
            end else begin
                mm = (tod / 60 + 1) % 1440;
                alarm_hour = toBcd(mm / 60); alarm_minute = toBcd(mm % 60);
            end
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
